// File: rtl/btn_event.sv
// Turns a debounced button level into one-cycle press/release/short/long/repeat
// events plus a held level, with all timing counted in ms_tck ticks.
module btn_event #(
  parameter logic [9:0] LONG_MS   = 10'd1000,
  parameter logic [9:0] REPEAT_MS = 10'd200,
  parameter logic       ACT_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  input  logic ms_tck,
  output logic press,
  output logic release_evt,
  output logic short_press,
  output logic long_press,
  output logic rpt,
  output logic held
);

  typedef enum logic [1:0] {LOCK, IDLE, PRESSED, HOLD} state_t;

  localparam logic [9:0] LONG_END = LONG_MS - 10'd1;
  localparam logic [9:0] RPT_END  = REPEAT_MS - 10'd1;
  localparam logic       RPT_EN   = (REPEAT_MS != 10'd0);

  state_t     state;
  logic [9:0] cnt;
  logic       act;

  assign act = ACT_LOW ? ~sig_in : sig_in;

  // Release is checked before the tick so a dropping button never also fires long/rpt.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= LOCK;
      cnt         <= 10'd0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      rpt         <= 1'b0;
      held        <= 1'b0;
    end else begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      rpt         <= 1'b0;
      case (state)
        LOCK: begin
          held <= 1'b0;
          if (!act) state <= IDLE;
        end
        IDLE: begin
          held <= 1'b0;
          if (act) begin
            press <= 1'b1;
            held  <= 1'b1;
            cnt   <= 10'd0;
            state <= PRESSED;
          end
        end
        PRESSED: begin
          if (!act) begin
            release_evt <= 1'b1;
            short_press <= 1'b1;
            held        <= 1'b0;
            state       <= IDLE;
          end else if (ms_tck) begin
            if (cnt == LONG_END) begin
              long_press <= 1'b1;
              cnt        <= 10'd0;
              state      <= HOLD;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
        HOLD: begin
          if (!act) begin
            release_evt <= 1'b1;
            held        <= 1'b0;
            state       <= IDLE;
          end else if (ms_tck && RPT_EN) begin
            // With repeat disabled the counter parks at zero instead of wrapping.
            if (cnt == RPT_END) begin
              rpt <= 1'b1;
              cnt <= 10'd0;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
        end
        default: begin
          held  <= 1'b0;
          state <= LOCK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event: expected event vectors are queued as each step is
// driven and compared against the registered outputs one edge later.
module tb_btn_event;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig_in = 1'b1;
  logic ms_tck = 1'b0;

  logic a_press, a_rel, a_short, a_long, a_rpt, a_held;
  logic b_press, b_rel, b_short, b_long, b_rpt, b_held;

  int checks = 0;
  int errors = 0;

  // {press, release, short_press, long_press, rpt, held}
  localparam logic [5:0] N  = 6'b000000;
  localparam logic [5:0] H  = 6'b000001;
  localparam logic [5:0] P  = 6'b100001;
  localparam logic [5:0] RS = 6'b011000;
  localparam logic [5:0] R  = 6'b010000;
  localparam logic [5:0] L  = 6'b000101;
  localparam logic [5:0] T  = 6'b000011;

  logic [5:0] exp_q[$];

  btn_event #(.LONG_MS(10'd5), .REPEAT_MS(10'd2), .ACT_LOW(1'b1)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ms_tck(ms_tck),
    .press(a_press), .release_evt(a_rel), .short_press(a_short),
    .long_press(a_long), .rpt(a_rpt), .held(a_held)
  );

  btn_event #(.LONG_MS(10'd5), .REPEAT_MS(10'd0), .ACT_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .ms_tck(ms_tck),
    .press(b_press), .release_evt(b_rel), .short_press(b_short),
    .long_press(b_long), .rpt(b_rpt), .held(b_held)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] a_vec();
    return {a_press, a_rel, a_short, a_long, a_rpt, a_held};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic s, input logic t, input logic [5:0] e);
    logic [5:0] want;
    sig_in = s;
    ms_tck = t;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    check(tag, {26'd0, a_vec()}, {26'd0, want});
    ms_tck = 1'b0;
  endtask

  // One tick cycle followed by a quiet cycle, so non-tick cycles must not count.
  task automatic tick(input string tag, input logic s, input logic [5:0] e_tick, input logic [5:0] e_gap);
    step(tag, s, 1'b1, e_tick);
    step(tag, s, 1'b0, e_gap);
  endtask

  int long_cnt;
  int rpt_cnt;
  int press_cnt;

  initial begin
    // Reset while pressed, held through ten ticks: LOCK must stay silent.
    step("reset_state", 1'b0, 1'b0, N);
    step("reset_state2", 1'b0, 1'b1, N);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick("lock_hold", 1'b0, N, N);
    step("lock_release", 1'b1, 1'b0, N);
    step("first_press", 1'b0, 1'b0, P);

    // Short press: three ticks then release.
    for (int i = 0; i < 3; i++) tick("short_held", 1'b0, H, H);
    step("short_release", 1'b1, 1'b0, RS);
    step("short_after", 1'b1, 1'b0, N);

    // Long press with repeats on ticks 7 and 9.
    step("long_press_in", 1'b0, 1'b0, P);
    for (int i = 1; i <= 4; i++) tick("long_pre", 1'b0, H, H);
    tick("long_fire", 1'b0, L, H);
    tick("rpt_gap6", 1'b0, H, H);
    tick("rpt_fire7", 1'b0, T, H);
    tick("rpt_gap8", 1'b0, H, H);
    tick("rpt_fire9", 1'b0, T, H);
    step("long_release", 1'b1, 1'b0, R);
    step("long_after", 1'b1, 1'b0, N);

    // Release coincident with the fifth tick: short wins, no long.
    step("race_press", 1'b0, 1'b0, P);
    for (int i = 1; i <= 4; i++) tick("race_pre", 1'b0, H, H);
    step("race_release", 1'b1, 1'b1, RS);
    step("race_idle", 1'b1, 1'b0, N);
    step("race_repress", 1'b0, 1'b0, P);
    step("race_rerelease", 1'b1, 1'b0, RS);

    // Reset asserted in HOLD: no release, then LOCK until the button lets go.
    step("rst_press", 1'b0, 1'b0, P);
    for (int i = 1; i <= 4; i++) tick("rst_pre", 1'b0, H, H);
    tick("rst_long", 1'b0, L, H);
    rst = 1'b0;
    step("rst_mid_hold", 1'b0, 1'b0, N);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) tick("rst_lock", 1'b0, N, N);
    step("rst_unlock", 1'b1, 1'b0, N);
    step("rst_repress", 1'b0, 1'b0, P);
    step("rst_rerelease", 1'b1, 1'b0, RS);

    // Repeat-disabled instance: hold 20 ticks, expect one long and no rpt.
    long_cnt = 0;
    rpt_cnt = 0;
    press_cnt = 0;
    sig_in = 1'b0;
    @(posedge clk);
    #1;
    press_cnt += int'(b_press);
    for (int i = 0; i < 20; i++) begin
      ms_tck = 1'b1;
      @(posedge clk);
      #1;
      long_cnt += int'(b_long);
      rpt_cnt += int'(b_rpt);
      ms_tck = 1'b0;
      @(posedge clk);
      #1;
      long_cnt += int'(b_long);
      rpt_cnt += int'(b_rpt);
    end
    check("norpt_press", press_cnt, 1);
    check("norpt_long", long_cnt, 1);
    check("norpt_rpt", rpt_cnt, 0);
    check("norpt_held", {31'd0, b_held}, 1);
    sig_in = 1'b1;
    @(posedge clk);
    #1;
    check("norpt_release", {29'd0, b_rel, b_short, b_held}, {29'd0, 3'b100});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event.md
# btn_event

Button event decoder that turns a debounced button level into single-cycle event pulses: press, release, short press, long press and auto-repeat. It sits directly behind each debounce instance in the user-input path and shares the same 1 ms tick. The capture/display control logic then consumes discrete events instead of levels.

## Interface
- `LONG_MS`, default `10'd1000`: ms ticks the button must be held before `long_press`. Legal range 1..1023.
- `REPEAT_MS`, default `10'd200`: ms ticks between `rpt` pulses after a long press. 0 disables repeat; legal range 0..1023.
- `ACT_LOW`, default `1'b1`: 1 means `sig_in` low = pressed; 0 means `sig_in` high = pressed.

- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `rst` input, 1 bit: synchronous, active-low reset.
- `sig_in` input, 1 bit: debounced button level; already synchronous to `clk`.
- `ms_tck` input, 1 bit: 1 ms tick, one `clk` cycle wide.
- `press` output, 1 bit: pulse on transition to pressed.
- `release` output, 1 bit: pulse on transition to released.
- `short_press` output, 1 bit: pulse on release before the long threshold.
- `long_press` output, 1 bit: pulse when the hold reaches `LONG_MS` ticks.
- `rpt` output, 1 bit: auto-repeat pulse while held after `long_press`.
- `held` output, 1 bit: level, 1 while a valid press is in progress.

## Operation
- `act` = `ACT_LOW` ? `~sig_in` : `sig_in`.
- Tick counter `cnt` is 10 bits.
- States:
  - LOCK: entered on reset. Stays until `act`=0, then goes to IDLE with no events. A button held through reset produces nothing until it is released and pressed again.
  - IDLE: `ms_tck` is ignored. On `act`=1: pulse `press`, clear `cnt`, go to PRESSED.
  - PRESSED:
    - If `act`=0: pulse `release` and `short_press`, go to IDLE.
    - Else on `ms_tck` with `cnt`==`LONG_MS`-1: pulse `long_press`, clear `cnt`, go to HOLD.
    - Else on `ms_tck`: increment `cnt`.
  - HOLD:
    - If `act`=0: pulse `release` only (no `short_press`), go to IDLE.
    - Else if `REPEAT_MS`≠0 and `ms_tck` with `cnt`==`REPEAT_MS`-1: pulse `rpt`, clear `cnt`.
    - Else on `ms_tck`: increment `cnt`.
- Release takes priority over a simultaneous `ms_tck`: no `long_press` or `rpt` fires in the cycle `act` drops.
- `held` = 1 in PRESSED and HOLD, 0 in LOCK and IDLE.
- `cnt` never exceeds `LONG_MS`-1 or `REPEAT_MS`-1, so it cannot wrap.
- Pulses are mutually exclusive per cycle, except `release` with `short_press`.

## Timing
- All outputs are registered. Reset values: `press`=0, `release`=0, `short_press`=0, `long_press`=0, `rpt`=0, `held`=0, `cnt`=0, state LOCK.
- Latency: a condition seen at rising edge k puts its pulse high from edge k until edge k+1, i.e. exactly one `clk` cycle.
- `held` changes in the same cycle as the corresponding `press`/`release` pulse.
- `long_press` is driven by the `LONG_MS`-th `ms_tck` strictly after the `press` cycle. A tick in the same cycle the press is detected does not count.
- After `long_press`, the first `rpt` fires on the `REPEAT_MS`-th subsequent tick, then every `REPEAT_MS` ticks.
- `rst` low mid-operation: all outputs drop to 0 on the next edge and the state returns to LOCK. No `release` pulse is generated.

## Test plan
Bench parameters: `LONG_MS`=5, `REPEAT_MS`=2, `ACT_LOW`=1.
- Reset with `sig_in`=0 (pressed), hold 10 ticks, then `sig_in`=1: no pulse at all and `held`=0 throughout; then `sig_in`=0 gives `press` one cycle later.
- From IDLE, press, wait 3 ticks, release: exactly one `press`, then one cycle with `release`=`short_press`=1; `held` high between the two pulses; `long_press` never fires.
- Hold for 9 ticks: `long_press` on tick 5, `rpt` on ticks 7 and 9; then release gives `release`=1 and `short_press`=0.
- Release in the same cycle as the 5th tick: `release` and `short_press` fire, `long_press` does not; state returns to IDLE.
- `rst` driven low while in HOLD: next cycle all outputs are 0 with no `release`; button still pressed after reset yields no events until it is released.
- `REPEAT_MS`=0 build, hold 20 ticks: one `long_press`, zero `rpt`.
